// File: rtl/watch_pkg.sv
// Shared constants for the keypad time-setting controller: key codes, FSM states,
// per-digit limits and BCD field positions within the hh:mm:ss word.
package watch_pkg;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {IDLE, ENTRY, CONFIRM, LOAD} state_t;

    localparam logic [3:0] LIM_H_TEN    = 4'd2;
    localparam logic [3:0] LIM_H_ONE    = 4'd9;
    localparam logic [3:0] LIM_H_ONE_20 = 4'd3;
    localparam logic [3:0] LIM_M_TEN    = 4'd5;
    localparam logic [3:0] LIM_M_ONE    = 4'd9;
    localparam logic [3:0] LIM_S_TEN    = 4'd5;
    localparam logic [3:0] LIM_S_ONE    = 4'd9;

    localparam int H_TEN_LSB = 20;
    localparam int H_ONE_LSB = 16;
    localparam int M_TEN_LSB = 12;
    localparam int M_ONE_LSB = 8;
    localparam int S_TEN_LSB = 4;
    localparam int S_ONE_LSB = 0;

    // Edit position 0 is the most significant nibble (h_ten).
    function automatic logic [4:0] digit_lsb(input logic [2:0] pos);
        return 5'(H_TEN_LSB - 4 * int'(pos));
    endfunction
endpackage

// File: rtl/watch_digit_check.sv
// Combinational range check of one BCD digit against its position's limit.
module watch_digit_check
    import watch_pkg::*;
(
    input  logic [2:0] i_pos,
    input  logic [3:0] i_digit,
    input  logic [3:0] i_h_ten,
    output logic       o_ok
);
    logic [3:0] w_lim;
    logic       w_pos_ok;

    always_comb begin
        w_lim    = 4'd0;
        w_pos_ok = 1'b1;
        case (i_pos)
            3'd0:    w_lim = LIM_H_TEN;
            3'd1:    w_lim = (i_h_ten == 4'd2) ? LIM_H_ONE_20 : LIM_H_ONE;
            3'd2:    w_lim = LIM_M_TEN;
            3'd3:    w_lim = LIM_M_ONE;
            3'd4:    w_lim = LIM_S_TEN;
            3'd5:    w_lim = LIM_S_ONE;
            default: w_pos_ok = 1'b0;
        endcase
    end

    assign o_ok = w_pos_ok && (i_digit <= w_lim);
endmodule

// File: rtl/watch_set_ctrl.sv
// Keypad-driven hh:mm:ss setting controller: shadow entry, validation, freeze,
// commit load strobe, plus display select and blink mask for the scan logic.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int CLK_HZ        = 1000,
    parameter int TIMEOUT_S     = 10,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_key_code,
    input  logic        i_key_valid,
    input  logic [23:0] i_cur_time,
    output logic        o_set_active,
    output logic        o_pause,
    output logic        o_load_pulse,
    output logic [23:0] o_load_time,
    output logic [23:0] o_disp_time,
    output logic [2:0]  o_edit_pos,
    output logic [5:0]  o_blink_mask,
    output logic        o_entry_err
);
    localparam int TO_CYC = TIMEOUT_S * CLK_HZ;
    localparam int TO_W   = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam int BL_CYC = BLINK_HALF_MS * CLK_HZ / 1000;
    localparam int BL_W   = (BL_CYC > 1) ? $clog2(BL_CYC) : 1;

    state_t           r_state;
    logic [23:0]      r_shadow;
    logic [2:0]       r_pos;
    logic [TO_W-1:0]  r_to_cnt;
    logic [BL_W-1:0]  r_bl_cnt;
    logic             r_phase;
    logic             r_kv, r_kv_q;
    logic [3:0]       r_code;
    logic             r_load_pulse, r_entry_err;

    logic             w_is_digit, w_evt, w_digit_ok, w_hours_ok, w_h_one_ok;
    logic [4:0]       w_lsb;

    // A-D never produce an event, so they neither error nor restart the timeout.
    assign w_is_digit = (r_code <= 4'd9);
    assign w_evt      = r_kv && !r_kv_q &&
                        (w_is_digit || r_code == KEY_STAR || r_code == KEY_HASH);
    assign w_lsb      = digit_lsb(r_pos);

    watch_digit_check u_entry_chk (
        .i_pos   (r_pos),
        .i_digit (r_code),
        .i_h_ten (r_shadow[H_TEN_LSB +: 4]),
        .o_ok    (w_digit_ok)
    );

    watch_digit_check u_hours_chk (
        .i_pos   (3'd1),
        .i_digit (r_shadow[H_ONE_LSB +: 4]),
        .i_h_ten (r_shadow[H_TEN_LSB +: 4]),
        .o_ok    (w_h_one_ok)
    );

    assign w_hours_ok = w_h_one_ok && (r_shadow[H_TEN_LSB +: 4] <= LIM_H_TEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kv   <= 1'b0;
            r_kv_q <= 1'b0;
            r_code <= 4'd0;
        end else begin
            r_kv   <= i_key_valid;
            r_kv_q <= r_kv;
            r_code <= i_key_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shadow     <= 24'd0;
            r_pos        <= 3'd0;
            r_to_cnt     <= '0;
            r_bl_cnt     <= '0;
            r_phase      <= 1'b0;
            r_load_pulse <= 1'b0;
            r_entry_err  <= 1'b0;
        end else begin
            r_load_pulse <= 1'b0;
            r_entry_err  <= 1'b0;

            if (r_bl_cnt == BL_W'(BL_CYC - 1)) begin
                r_bl_cnt <= '0;
                r_phase  <= !r_phase;
            end else begin
                r_bl_cnt <= r_bl_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_to_cnt <= '0;
                    if (w_evt && r_code == KEY_STAR) begin
                        r_shadow <= i_cur_time;
                        r_pos    <= 3'd0;
                        r_state  <= ENTRY;
                        r_bl_cnt <= '0;
                        r_phase  <= 1'b0;
                    end
                end
                ENTRY, CONFIRM: begin
                    if (w_evt) begin
                        r_to_cnt <= '0;
                        if (r_code == KEY_HASH) begin
                            if (w_hours_ok) begin
                                r_state      <= LOAD;
                                r_load_pulse <= 1'b1;
                            end else begin
                                r_entry_err  <= 1'b1;
                            end
                        end else if (r_state == CONFIRM) begin
                            if (r_code == KEY_STAR) begin
                                r_state  <= ENTRY;
                                r_pos    <= 3'd5;
                                r_bl_cnt <= '0;
                                r_phase  <= 1'b0;
                            end
                        end else if (r_code == KEY_STAR) begin
                            if (r_pos != 3'd0) r_pos   <= r_pos - 1'b1;
                            else               r_state <= IDLE;
                        end else if (w_digit_ok) begin
                            r_shadow[w_lsb +: 4] <= r_code;
                            if (r_pos == 3'd5) r_state <= CONFIRM;
                            else               r_pos   <= r_pos + 1'b1;
                        end else begin
                            r_entry_err <= 1'b1;
                        end
                    end else if (r_to_cnt == TO_W'(TO_CYC - 1)) begin
                        r_to_cnt <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    r_to_cnt <= '0;
                    r_pos    <= 3'd0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_blink_mask = 6'd0;
        o_edit_pos   = 3'd0;
        case (r_state)
            ENTRY: begin
                o_blink_mask = 6'(r_phase) << (3'd5 - r_pos);
                o_edit_pos   = r_pos;
            end
            CONFIRM: begin
                o_blink_mask = {6{r_phase}};
                o_edit_pos   = 3'd6;
            end
            default: ;
        endcase
    end

    assign o_set_active = (r_state != IDLE);
    assign o_pause      = o_set_active;
    assign o_load_pulse = r_load_pulse;
    assign o_load_time  = r_shadow;
    assign o_disp_time  = o_set_active ? r_shadow : i_cur_time;
    assign o_entry_err  = r_entry_err;
endmodule
